// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one WIDTH-bit ALU between two requesters. Each requester presents an
// operation (opcode + two operands) on a valid/ready channel. A round-robin
// arbiter picks one operation per cycle, the ALU evaluates it combinationally,
// and the result is captured in a single-entry response buffer. The buffer is
// drained through a backpressured valid/ready response channel that carries
// the ID of the requester that issued the operation.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_valid/ready        requester 0 handshake
//   req0_op/a/b             requester 0 opcode and operands
//   req1_valid/ready        requester 1 handshake
//   req1_op/a/b             requester 1 opcode and operands
//   rsp_valid/ready         response handshake
//   rsp_id                  requester that issued the buffered operation
//   rsp_data                buffered ALU result
//   rsp_err                 buffered operation used an illegal opcode
//
// Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 shl1, 5 shr1 (logical),
//          6/7 illegal -> data 0, err 1.
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // ALU: returns {err, data}. Add/sub wrap modulo 2^WIDTH, shifts ignore B
    // and zero-fill, illegal opcodes yield zero data with err set.
    function automatic logic [WIDTH:0] alu_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        logic             err;
        res = {WIDTH{1'b0}};
        err = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SHL:  res = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  res = {1'b0, a[WIDTH-1:1]};
            default: begin
                res = {WIDTH{1'b0}};
                err = 1'b1;
            end
        endcase
        return {err, res};
    endfunction

    // State and buffer registers
    state_t           state_q, state_d;
    logic             last_q,  last_d;
    logic             rsp_id_q,   rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q,  rsp_err_d;

    // Arbitration / datapath signals
    logic             can_acc_s;
    logic             any_valid_s;
    logic             grant_s;
    logic             acc_s;
    logic [2:0]       gnt_op_s;
    logic [WIDTH-1:0] gnt_a_s;
    logic [WIDTH-1:0] gnt_b_s;
    logic [WIDTH:0]   alu_res_s;

    // Buffer can take a new result when empty, or when the held result leaves
    // in this same cycle (pass-through refill keeps 1 op/cycle).
    assign can_acc_s = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & rsp_ready);

    // Round-robin grant: on contention favour the requester not served last;
    // a lone requester is always granted.
    always_comb begin
        grant_s     = 1'b0;
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = can_acc_s & req0_valid & ~grant_s;
    assign req1_ready = can_acc_s & req1_valid &  grant_s;
    assign acc_s      = can_acc_s & any_valid_s;

    // Operand mux feeding the shared ALU
    always_comb begin
        gnt_op_s = req0_op;
        gnt_a_s  = req0_a;
        gnt_b_s  = req0_b;
        if (grant_s) begin
            gnt_op_s = req1_op;
            gnt_a_s  = req1_a;
            gnt_b_s  = req1_b;
        end else begin
            gnt_op_s = req0_op;
            gnt_a_s  = req0_a;
            gnt_b_s  = req0_b;
        end
    end

    assign alu_res_s = alu_f(gnt_op_s, gnt_a_s, gnt_b_s);

    // Next-state logic for the buffer FSM and the buffered payload
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_EMPTY: begin
                if (acc_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !acc_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Payload only changes on accept, so it stays stable under backpressure.
        if (acc_s) begin
            last_d     = grant_s;
            rsp_id_d   = grant_s;
            rsp_data_d = alu_res_s[WIDTH-1:0];
            rsp_err_d  = alu_res_s[WIDTH];
        end else begin
            last_d     = last_q;
            rsp_id_d   = rsp_id_q;
            rsp_data_d = rsp_data_q;
            rsp_err_d  = rsp_err_q;
        end
    end

    // State register; last resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            last_q     <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= {WIDTH{1'b0}};
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
